// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-in-ID and data-memory-wait stalls.
// Optional stall counter output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       id_branch_taken,
  input  logic [4:0] id_ex_dst,
  input  logic [4:0] ex_mem_dst,
  input  logic       id_ex_regwrite,
  input  logic       ex_mem_regwrite,
  input  logic       id_ex_memread,
  input  logic       ex_mem_memread,
  input  logic       ex_mem_memwrite,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_write,
  output logic       ex_mem_write,
  output logic       id_ex_bubble,
  output logic       if_id_flush
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {RUN, BR_WAIT, MEM_WAIT} state_t;

  state_t state_q, state_d;

  logic mem_busy, load_use, id_ex_hit, ex_mem_hit;
  logic br_alu, br_load, br_memload;
  logic freeze, stall;

  // ex_mem_regwrite is part of the pipeline bus but no hazard rule depends on it.
  logic unused_ex_mem_regwrite;
  assign unused_ex_mem_regwrite = ex_mem_regwrite;

  assign mem_busy   = (ex_mem_memread | ex_mem_memwrite) & ~dmem_ready;
  assign load_use   = id_ex_memread & (id_ex_dst != 5'd0) &
                      ((id_ex_dst == if_id_rs) | (id_uses_rt & (id_ex_dst == if_id_rt)));
  assign id_ex_hit  = (id_ex_dst != 5'd0) & ((id_ex_dst == if_id_rs) | (id_ex_dst == if_id_rt));
  assign ex_mem_hit = (ex_mem_dst != 5'd0) & ((ex_mem_dst == if_id_rs) | (ex_mem_dst == if_id_rt));
  assign br_alu     = id_is_branch & ~id_ex_regwrite & ~id_ex_memread & id_ex_hit;
  assign br_load    = id_is_branch & ~id_ex_regwrite &  id_ex_memread & id_ex_hit;
  assign br_memload = id_is_branch & ex_mem_memread & ex_mem_hit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end else if (br_load) begin
          stall   = 1'b1;
          state_d = BR_WAIT;
        end else if (load_use | br_alu | br_memload) begin
          stall   = 1'b1;
        end
      end
      BR_WAIT: begin
        state_d = RUN;
        if (mem_busy) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          stall   = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) freeze  = 1'b1;
        else             state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Reset forces the outputs directly so a mid-stall reset takes effect immediately.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if_id_flush  = id_branch_taken;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cnt <= 16'd0;
    else if (!pc_write && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: if_id_rs, if_id_rt  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports: id_uses_rt  in  1  the ID instruction reads rt; id_is_branch  in  1  the ID instruction is a branch resolved in ID.
REQ-005 SHALL have ports: id_branch_taken  in  1  the ID branch resolves taken this cycle.
REQ-006 SHALL have ports: id_ex_dst, ex_mem_dst  in  5 each  destination register of the instruction in ID/EX and in EX/MEM.
REQ-007 SHALL have ports: id_ex_regwrite, ex_mem_regwrite  in  1 each  active-low; 0 means the instruction writes the register file.
REQ-008 SHALL have ports: id_ex_memread, ex_mem_memread, ex_mem_memwrite  in  1 each  active-high load/store flags.
REQ-009 SHALL have ports: dmem_ready  in  1  data-memory handshake; 1 means the EX/MEM access completes this cycle.
REQ-010 SHALL have ports: pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  stage register enables.
REQ-011 SHALL have ports: id_ex_bubble, if_id_flush  out  1 each  insert NOP into ID/EX; squash IF/ID.

Function
REQ-012 SHALL hold states RUN, BR_WAIT and MEM_WAIT in a registered FSM; all outputs are combinational from state and inputs.
REQ-013 mem_busy SHALL equal (ex_mem_memread|ex_mem_memwrite)&~dmem_ready.
REQ-014 load_use SHALL equal id_ex_memread & id_ex_dst!=0 & (id_ex_dst==if_id_rs | (id_uses_rt & id_ex_dst==if_id_rt)).
REQ-015 br_alu SHALL equal id_is_branch & ~id_ex_regwrite & ~id_ex_memread & id_ex_dst!=0 & id_ex_dst matches if_id_rs or if_id_rt; br_load is the same term with id_ex_memread=1.
REQ-016 br_memload SHALL equal id_is_branch & ex_mem_memread & ex_mem_dst!=0 & ex_mem_dst matches if_id_rs or if_id_rt.
REQ-017 In RUN with mem_busy, the block SHALL freeze: all four enables 0, id_ex_bubble 0, next state MEM_WAIT; priority over every other condition.
REQ-018 In MEM_WAIT, the block SHALL freeze while dmem_ready=0; on dmem_ready=1 enables SHALL be 1 that same cycle and next state RUN.
REQ-019 In RUN with br_load, the block SHALL set pc_write=0, if_id_write=0, id_ex_bubble=1; next state BR_WAIT.
REQ-020 In BR_WAIT, the block SHALL unconditionally stall (pc_write=0, if_id_write=0, id_ex_bubble=1); next RUN; mem_busy overrides this to a freeze and MEM_WAIT, and BR_WAIT re-evaluates from RUN afterwards.
REQ-021 In RUN with load_use, br_alu or br_memload (no mem_busy), the block SHALL stall one cycle with a bubble and remain in RUN.
REQ-022 if_id_flush SHALL be 1 only when id_branch_taken=1 and the block is neither stalling nor freezing.
REQ-023 Otherwise all enables SHALL be 1, and id_ex_bubble and if_id_flush SHALL be 0.
REQ-024 Register 0 SHALL never cause a stall.

Reset
REQ-025 While rst_n=0: state is RUN; all enables are 0; id_ex_bubble=1; if_id_flush=0; stall_cnt (if present) is 0.
REQ-026 Reset assertion mid-stall or mid-MEM_WAIT SHALL abort it immediately; first cycle after release evaluates from RUN.

Configuration
REQ-027 With HAZARD_STALL_CNT_EN defined, the block SHALL add output stall_cnt out 16: incremented on every cycle with pc_write=0 outside reset, saturating at 16'hFFFF.
REQ-028 Without HAZARD_STALL_CNT_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-029 Load-use: id_ex_memread=1, id_ex_dst=5, if_id_rs=5 -> one cycle pc_write=0, id_ex_bubble=1, then enables all 1.
REQ-030 Branch-on-load: id_is_branch=1, id_ex_memread=1, id_ex_dst=8, if_id_rt=8, id_uses_rt=1 -> exactly two stall cycles (RUN->BR_WAIT->RUN).
REQ-031 Memory wait: ex_mem_memread=1, dmem_ready=0 for 3 cycles then 1 -> 3 frozen cycles, enables 1 on the ready cycle; with a simultaneous load_use, the freeze wins.
REQ-032 Register zero: load to id_ex_dst=0, if_id_rs=0 -> no stall.
REQ-033 Reset during MEM_WAIT: rst_n low one cycle -> outputs take reset values; after release with dmem_ready=1 -> enables 1.
REQ-034 HAZARD_STALL_CNT_EN: preload stall_cnt=16'hFFFE, apply 3 stall cycles -> stall_cnt=16'hFFFF and holds.
